// File: rtl/maxpool2d.sv
// Streaming 2x2 stride-2 max pool; even-row horizontal maxima parked in a half-width line buffer.
// Latency 1 cycle after the odd-row/odd-col beat; accepts a pixel every cycle, so no backpressure.
module maxpool2d #(
  parameter int N          = 16,
  parameter int CHANNEL    = 3,
  parameter int INPUT_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] pool_dout,
  output logic                 pool_dout_vld,
  output logic                 pool_dout_end
);

  localparam int OUTPUT_SIZE = INPUT_SIZE / 2;
  localparam int CW = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam int AW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  logic [CW-1:0]        col, row;
  logic [CHANNEL*N-1:0] h, hm, pm, lb_rd;
  logic [CHANNEL*N-1:0] lb [OUTPUT_SIZE];
  logic [AW-1:0]        lb_addr;
  logic                 col_last, row_last;

  assign col_last = (col == LAST);
  assign row_last = (row == LAST);
  assign lb_addr  = AW'(col >> 1);
  assign lb_rd    = lb[lb_addr];

  // Per-channel signed maxima: hm is the horizontal pair, pm folds in the stored even row.
  always_comb begin
    hm = h;
    pm = lb_rd;
    for (int c = 0; c < CHANNEL; c++) begin
      if ($signed(input_din[c*N +: N]) > $signed(h[c*N +: N]))
        hm[c*N +: N] = input_din[c*N +: N];
      if ($signed(hm[c*N +: N]) > $signed(lb_rd[c*N +: N]))
        pm[c*N +: N] = hm[c*N +: N];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col           <= '0;
      row           <= '0;
      h             <= '0;
      pool_dout     <= '0;
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b0;
    end else begin
      pool_dout_vld <= input_vld && row[0] && col[0];
      pool_dout_end <= input_vld && row_last && col_last;
      if (input_vld) begin
        if (!col[0])
          h <= input_din;
        if (row[0] && col[0])
          pool_dout <= pm;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Every entry is rewritten in each even row before the odd row reads it, so no reset needed.
  always_ff @(posedge clk) begin
    if (input_vld && !row[0] && col[0])
      lb[lb_addr] <= hm;
  end

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: a 1-channel 4x4 instance and a 3-channel 6x6 instance, scoreboarded
// against a window-based 2x2 max model with cycle-exact latency.
module tb_maxpool2d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld_a, dvld_a, dend_a;
  logic [15:0] din_a, dout_a;
  logic        vld_b, dvld_b, dend_b;
  logic [47:0] din_b, dout_b;

  maxpool2d #(.N(16), .CHANNEL(1), .INPUT_SIZE(4)) dut_a (
    .clk(clk), .rst_n(rst), .input_vld(vld_a), .input_din(din_a),
    .pool_dout(dout_a), .pool_dout_vld(dvld_a), .pool_dout_end(dend_a)
  );

  maxpool2d #(.N(16), .CHANNEL(3), .INPUT_SIZE(6)) dut_b (
    .clk(clk), .rst_n(rst), .input_vld(vld_b), .input_din(din_b),
    .pool_dout(dout_b), .pool_dout_vld(dvld_b), .pool_dout_end(dend_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [47:0] dat;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] obs_a[$];
  logic        obs_end_a[$];
  logic [47:0] obs_b[$];
  int          vcnt_a, ecnt_a, vcnt_b, ecnt_b;
  logic [15:0] img_a[4][4];
  logic [47:0] img_b[6][6];
  int          ra, ca, rb, cb;

  function automatic logic signed [15:0] smax(input logic signed [15:0] x, input logic signed [15:0] y);
    return (x > y) ? x : y;
  endfunction

  task automatic beat_a(input logic [15:0] v);
    exp_t e;
    @(posedge clk); #1;
    vld_a = 1'b1;
    din_a = v;
    img_a[ra][ca] = v;
    if (ra % 2 == 1 && ca % 2 == 1) begin
      e.dat = '0;
      e.dat[15:0] = smax(smax(img_a[ra-1][ca-1], img_a[ra-1][ca]), smax(img_a[ra][ca-1], img_a[ra][ca]));
      e.last = (ra == 3 && ca == 3);
      e.cyc  = cyc + 1;
      qa.push_back(e);
    end
    if (ca == 3) begin ca = 0; ra = (ra == 3) ? 0 : ra + 1; end
    else ca++;
  endtask

  task automatic beat_b(input logic [47:0] px);
    exp_t e;
    @(posedge clk); #1;
    vld_b = 1'b1;
    din_b = px;
    img_b[rb][cb] = px;
    if (rb % 2 == 1 && cb % 2 == 1) begin
      e.dat = '0;
      for (int ch = 0; ch < 3; ch++)
        e.dat[ch*16 +: 16] = smax(smax(img_b[rb-1][cb-1][ch*16 +: 16], img_b[rb-1][cb][ch*16 +: 16]),
                                  smax(img_b[rb][cb-1][ch*16 +: 16], img_b[rb][cb][ch*16 +: 16]));
      e.last = (rb == 5 && cb == 5);
      e.cyc  = cyc + 1;
      qb.push_back(e);
    end
    if (cb == 5) begin cb = 0; rb = (rb == 5) ? 0 : rb + 1; end
    else cb++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vld_a = 1'b0;
      vld_b = 1'b0;
    end
  endtask

  task automatic ramp_a(input int base);
    for (int k = 0; k < 16; k++) beat_a(16'(base + k));
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_end_a.delete(); obs_b.delete();
    vcnt_a = 0; ecnt_a = 0; vcnt_b = 0; ecnt_b = 0;
  endtask

  task automatic mon_a();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dvld_a === 1'b1) begin
        vcnt_a++;
        if (dend_a === 1'b1) ecnt_a++;
        obs_a.push_back(dout_a);
        obs_end_a.push_back(dend_a);
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL a_unexpected_vld: got dout=%0d end=%b at cycle %0d, required no output", $signed(dout_a), dend_a, cyc);
        end else begin
          e = qa.pop_front();
          if (dout_a !== e.dat[15:0] || dend_a !== e.last || cyc !== e.cyc) begin
            failures++;
            $display("FAIL a_output: got dout=%0d end=%b cyc=%0d, required dout=%0d end=%b cyc=%0d",
                     $signed(dout_a), dend_a, cyc, $signed(e.dat[15:0]), e.last, e.cyc);
          end
        end
      end else if (dend_a !== 1'b0) begin
        failures++;
        $display("FAIL a_end_without_vld: got end=%b at cycle %0d, required 0", dend_a, cyc);
      end
      if (qa.size() > 0 && qa[0].cyc < cyc) begin
        e = qa.pop_front();
        failures++;
        $display("FAIL a_missing_output: got none by cycle %0d, required dout=%0d at cycle %0d", cyc, $signed(e.dat[15:0]), e.cyc);
      end
    end
  endtask

  task automatic mon_b();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dvld_b === 1'b1) begin
        vcnt_b++;
        if (dend_b === 1'b1) ecnt_b++;
        obs_b.push_back(dout_b);
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL b_unexpected_vld: got dout=%h at cycle %0d, required no output", dout_b, cyc);
        end else begin
          e = qb.pop_front();
          if (dout_b !== e.dat || dend_b !== e.last || cyc !== e.cyc) begin
            failures++;
            $display("FAIL b_output: got dout=%h end=%b cyc=%0d, required dout=%h end=%b cyc=%0d",
                     dout_b, dend_b, cyc, e.dat, e.last, e.cyc);
          end
        end
      end else if (dend_b !== 1'b0) begin
        failures++;
        $display("FAIL b_end_without_vld: got end=%b at cycle %0d, required 0", dend_b, cyc);
      end
      if (qb.size() > 0 && qb[0].cyc < cyc) begin
        e = qb.pop_front();
        failures++;
        $display("FAIL b_missing_output: got none by cycle %0d, required dout=%h at cycle %0d", cyc, e.dat, e.cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout_a, dvld_a, dend_a} !== 18'd0) begin
      failures++;
      $display("FAIL reset_a: got dout=%h vld=%b end=%b, required all 0", dout_a, dvld_a, dend_a);
    end
    checks++;
    if ({dout_b, dvld_b, dend_b} !== 50'd0) begin
      failures++;
      $display("FAIL reset_b: got dout=%h vld=%b end=%b, required all 0", dout_b, dvld_b, dend_b);
    end
    rst = 1'b0;
    ra = 0; ca = 0; rb = 0; cb = 0;
  endtask

  task automatic test_ramp();
    int ev[4];
    ev = '{5, 7, 13, 15};
    clear_obs();
    ramp_a(0);
    idle(3);
    checks++;
    if (obs_a.size() != 4 || ecnt_a != 1) begin
      failures++;
      $display("FAIL ramp_count: got %0d outputs %0d ends, required 4 and 1", obs_a.size(), ecnt_a);
    end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== 16'(ev[i]) || obs_end_a[i] !== (i == 3)) begin
        failures++;
        $display("FAIL ramp_value[%0d]: got %0d end=%b, required %0d end=%b", i, $signed(obs_a[i]), obs_end_a[i], ev[i], i == 3);
      end
    end
  endtask

  task automatic test_signed();
    int ev[4];
    int win[16];
    ev  = '{-11, -9, -3, -1};
    win = '{-32768, 32767, 1, 2, 0, -1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    clear_obs();
    ramp_a(-16);
    idle(3);
    checks++;
    if (obs_a.size() != 4) begin
      failures++;
      $display("FAIL signed_count: got %0d outputs, required 4", obs_a.size());
    end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== 16'(ev[i])) begin
        failures++;
        $display("FAIL signed_value[%0d]: got %0d, required %0d", i, $signed(obs_a[i]), ev[i]);
      end
    end
    clear_obs();
    for (int k = 0; k < 16; k++) beat_a(16'(win[k]));
    idle(3);
    checks++;
    if (obs_a.size() != 4 || obs_a[0] !== 16'h7fff) begin
      failures++;
      $display("FAIL signed_extremes: got %0d outputs first=%0d, required 4 outputs first=32767",
               obs_a.size(), obs_a.size() > 0 ? $signed(obs_a[0]) : 0);
    end
  endtask

  task automatic test_gaps();
    int ev[4];
    ev = '{5, 7, 13, 15};
    clear_obs();
    for (int k = 0; k < 16; k++) begin
      idle($urandom_range(0, 5));
      beat_a(16'(k));
    end
    idle(4);
    checks++;
    if (obs_a.size() != 4 || ecnt_a != 1) begin
      failures++;
      $display("FAIL gaps_count: got %0d outputs %0d ends, required 4 and 1", obs_a.size(), ecnt_a);
    end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== 16'(ev[i])) begin
        failures++;
        $display("FAIL gaps_value[%0d]: got %0d, required %0d", i, $signed(obs_a[i]), ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ev[12];
    ev = '{5, 7, 13, 15, 105, 107, 113, 115, 205, 207, 213, 215};
    clear_obs();
    ramp_a(0);
    ramp_a(100);
    ramp_a(200);
    idle(3);
    checks++;
    if (obs_a.size() != 12 || ecnt_a != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d outputs %0d ends, required 12 and 3", obs_a.size(), ecnt_a);
    end
    for (int i = 0; i < 12 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== 16'(ev[i]) || obs_end_a[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL b2b_value[%0d]: got %0d end=%b, required %0d end=%b", i, $signed(obs_a[i]), obs_end_a[i], ev[i], i % 4 == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ev[4];
    ev = '{5, 7, 13, 15};
    for (int k = 0; k < 9; k++) beat_a(16'(k));
    @(posedge clk); #1;
    rst = 1'b1;
    vld_a = 1'b0;
    ra = 0; ca = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout_a, dvld_a, dend_a} !== 18'd0) begin
      failures++;
      $display("FAIL reset_mid_zero: got dout=%0d vld=%b end=%b, required all 0", $signed(dout_a), dvld_a, dend_a);
    end
    rst = 1'b0;
    clear_obs();
    ramp_a(0);
    idle(3);
    checks++;
    if (obs_a.size() != 4 || ecnt_a != 1) begin
      failures++;
      $display("FAIL reset_mid_count: got %0d outputs %0d ends, required 4 and 1", obs_a.size(), ecnt_a);
    end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] !== 16'(ev[i])) begin
        failures++;
        $display("FAIL reset_mid_value[%0d]: got %0d, required %0d", i, $signed(obs_a[i]), ev[i]);
      end
    end
  endtask

  task automatic test_channels();
    logic [63:0] r;
    clear_obs();
    for (int k = 0; k < 36; k++) beat_b({16'(-3 * k), 16'(2 * k), 16'(k)});
    for (int k = 0; k < 36; k++) begin
      r = {$urandom(), $urandom()};
      beat_b(r[47:0]);
    end
    idle(3);
    checks++;
    if (vcnt_b != 18 || ecnt_b != 2) begin
      failures++;
      $display("FAIL chan_count: got %0d outputs %0d ends, required 18 and 2", vcnt_b, ecnt_b);
    end
    checks++;
    if (obs_b.size() == 0 || obs_b[0] !== {16'd0, 16'd14, 16'd7}) begin
      failures++;
      $display("FAIL chan_first: got %h, required %h", obs_b.size() > 0 ? obs_b[0] : 48'hx, {16'd0, 16'd14, 16'd7});
    end
  endtask

  initial begin
    rst = 1'b1;
    vld_a = 1'b0; din_a = '0;
    vld_b = 1'b0; din_b = '0;
    ra = 0; ca = 0; rb = 0; cb = 0;
    clear_obs();
    fork
      mon_a();
      mon_b();
    join_none
    test_reset();
    test_ramp();
    test_signed();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_channels();
    idle(2);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expectations, required 0/0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool2d.md
# maxpool2d

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the depthwise-separable convolution block. It consumes the `conv_dout` / `conv_dout_vld` pixel stream, one pixel per valid cycle, all channels in parallel, in row-major order. It emits one pooled pixel per 2×2 window, with a frame-end strobe, in the same `*_dout` / `*_dout_vld` / `*_dout_end` style so the next layer can chain on it. A half-width line buffer holds the horizontal maxima of each even row until the matching odd row arrives.

## Interface
- `N`, 16, bit width of one signed fixed-point element
- `CHANNEL`, 3, number of channels carried in parallel per pixel
- `INPUT_SIZE`, 6, input feature-map width = height; must be even and ≥ 2
- `OUTPUT_SIZE`, `INPUT_SIZE/2`, pooled map width = height; a derived localparam, not overridable

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge
- `rst_n`  input  1  reset, synchronous and active-high (reset when `rst_n`=1)
- `input_vld`  input  1  `input_din` carries a valid pixel this cycle
- `input_din`  input  `CHANNEL*N`  one pixel; channel c is in `[c*N +: N]`, signed two's complement
- `pool_dout`  output  `CHANNEL*N`  pooled pixel, same channel packing as `input_din`
- `pool_dout_vld`  output  1  one-cycle pulse, `pool_dout` is valid
- `pool_dout_end`  output  1  one-cycle pulse, coincident with the final pooled pixel of a frame

## Operation
- **Counters.** `col` and `row` each count 0..`INPUT_SIZE-1` and advance only on `input_vld`.
  - `col` wraps to 0 and increments `row` after `INPUT_SIZE-1`.
  - `row` wraps to 0 after the last pixel of the frame, so the next frame starts with no idle cycle.
- **Horizontal register `h`.** Per channel, on a valid pixel with `col` even, `h` captures `x`.
- **Horizontal max `hm`.** On a valid pixel with `col` odd, `hm = max(h, x)`, computed combinationally with a signed comparison.
- **Line buffer.** `OUTPUT_SIZE` entries × `CHANNEL*N` bits, addressed by `col>>1`.
  - Even `row`, odd `col`: write `lb[col>>1] = hm`. No output is produced.
  - Odd `row`, odd `col`: register `pool_dout = max(lb[col>>1], hm)` per channel and pulse `pool_dout_vld`.
- **Frame end.** `pool_dout_end` pulses with the output generated by input (`row`=`col`=`INPUT_SIZE-1`).
- **Channel independence.** Channels are fully independent; no cross-channel arithmetic.
- **Ties.** Equal operands give that value; the comparison choice is not observable.
- **Width.** Outputs are exact input values; no widening, saturation or rounding.
- **Input gaps.** Gaps in `input_vld` of any length are legal. All state holds and no output is produced during a gap.

## Timing
- **Reset values.** While `rst_n`=1:
  - `pool_dout`=0, `pool_dout_vld`=0, `pool_dout_end`=0.
  - `col`=0, `row`=0, `h`=0.
  - Line buffer contents are don't-care; they are always written in an even row before being read.
- **Latency.** 1 cycle. Output is registered in the cycle after the odd-row, odd-column input beat.
- **Pulse width.** `pool_dout_vld` and `pool_dout_end` are high for exactly one cycle each.
- **Holding.** `pool_dout` holds its last value while `pool_dout_vld`=0.
- **Throughput.** Accepts one pixel every cycle indefinitely. Produces at most one output every 2 cycles, so no backpressure is required.
- **Per-frame counts.** Exactly `OUTPUT_SIZE²` vld pulses and exactly one end pulse per frame.
- **Back-to-back frames.** Pixel 0 of frame k+1 may arrive in the cycle right after the last pixel of frame k. The end pulse of frame k appears in that same cycle, and frame k+1 is processed normally.
- **Reset mid-frame.** Partial-frame state is discarded. The first valid pixel after release is treated as (row 0, col 0), and no stale output or end pulse is emitted.
- **Unused input.** The upstream `conv_dout_end` is not an input; framing is derived purely from the counters.

## Test plan
- **Ramp frame.** `CHANNEL`=1, `INPUT_SIZE`=4, frame values 0..15 row-major at full rate.
  - Required: outputs 5, 7, 13, 15, in order.
  - Required: `pool_dout_end` only with 15, in the cycle after input 15.
- **Signed values.** `INPUT_SIZE`=4, all inputs negative (−16..−1 row-major).
  - Required: outputs −11, −9, −3, −1, proving the comparison is signed.
  - Required: a window {−32768, 32767, 0, −1} yields 32767.
- **Input gaps.** Same ramp as the first scenario with random `input_vld` gaps of 0–5 cycles.
  - Required: identical output sequence.
  - Required: every vld pulse exactly 1 cycle after the odd/odd input beat, and no vld during gaps.
- **Back-to-back frames.** Three frames with no idle cycles: ramp, ramp+100, ramp+200.
  - Required: 5, 7, 13, 15, 105, 107, 113, 115, 205, 207, 213, 215.
  - Required: end pulses on 15, 115, 215 only.
- **Reset mid-frame.** Assert `rst_n`=1 for 1 cycle after 9 pixels of a ramp frame, then send a full ramp frame.
  - Required: all outputs are 0 during reset.
  - Required: then exactly 5, 7, 13, 15 with one end pulse.
- **Channel isolation.** `CHANNEL`=3, `INPUT_SIZE`=6; channel c receives ramp×(c+1), with channel 2 negated.
  - Required: each channel matches an independent 2×2 max reference model.
  - Required: 9 outputs per frame.
